// File: rtl/line_clear.sv
// line_clear: removes full board rows, compacts the survivors downward and zero-fills the top
//   CLOCK_50, resetn       clock, async active-low reset
//   start                  one-cycle request for a clear pass (ignored while busy)
//   row_raddr / row_rdata  combinational board read port
//   row_we / row_waddr / row_wdata  board write port, one row per cycle
//   busy, done             pass in progress / one-cycle completion pulse
//   lines_cleared          rows removed by the last pass
//   total_lines            saturating running total of cleared rows
module line_clear #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    input  logic            start,
    output logic [4:0]      row_raddr,
    input  logic [COLS-1:0] row_rdata,
    output logic            row_we,
    output logic [4:0]      row_waddr,
    output logic [COLS-1:0] row_wdata,
    output logic            busy,
    output logic            done,
    output logic [2:0]      lines_cleared,
    output logic [7:0]      total_lines
);
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FILL, S_DONE} state_t;
    localparam logic [4:0] LAST = 5'(ROWS - 1);
    state_t     state, state_nx;
    logic [4:0] src, src_nx, dst, dst_nx;
    logic [2:0] cnt, cnt_nx;
    logic       full;
    logic [8:0] sum;
    assign full = &row_rdata;
    assign busy = state != S_IDLE;
    assign done = state == S_DONE;
    assign sum  = {1'b0, total_lines} + 9'(cnt);
    always_comb begin
        state_nx  = state;
        src_nx    = src;
        dst_nx    = dst;
        cnt_nx    = cnt;
        row_raddr = '0;
        row_we    = 1'b0;
        row_waddr = '0;
        row_wdata = '0;
        case (state)
            S_IDLE: if (start) begin
                state_nx = S_SCAN;
                src_nx   = LAST;
                dst_nx   = LAST;
                cnt_nx   = '0;
            end
            S_SCAN: begin
                row_raddr = src;
                if (full) begin
                    cnt_nx = (cnt == 3'd7) ? cnt : cnt + 3'd1;
                end else begin
                    // a survivor already in place needs no write, but dst still advances
                    row_we    = dst != src;
                    row_waddr = dst;
                    row_wdata = row_rdata;
                    dst_nx    = dst - 5'd1;
                end
                if (src == '0) state_nx = (cnt != '0 || full) ? S_FILL : S_DONE;
                else src_nx = src - 5'd1;
            end
            S_FILL: begin
                row_we    = 1'b1;
                row_waddr = dst;
                if (dst == '0) state_nx = S_DONE;
                else dst_nx = dst - 5'd1;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            src           <= '0;
            dst           <= '0;
            cnt           <= '0;
            lines_cleared <= '0;
            total_lines   <= '0;
        end else begin
            state <= state_nx;
            src   <= src_nx;
            dst   <= dst_nx;
            cnt   <= cnt_nx;
            if (state == S_DONE) begin
                lines_cleared <= cnt;
                total_lines   <= sum[8] ? 8'hFF : sum[7:0];
            end
        end
    end
endmodule
